// File: rtl/clz_decode.sv
// Inverse count-leading-zeros: rebuilds the canonical one-hot word and thermometer mask
// for a leading-zero count, resolving one count bit per cycle behind a valid/ready handshake.
module clz_decode #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [WIDTH-1:0] out_mask,
  output logic             out_sat
);

  localparam int unsigned KW = (CW > 1) ? $clog2(CW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CW - 1);
  localparam logic [CW-1:0] N_MAX  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    n_q, n_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] work_oh_q, work_oh_d;
  logic [WIDTH-1:0] work_mask_q, work_mask_d;
  logic [WIDTH-1:0] res_oh_q, res_oh_d;
  logic [WIDTH-1:0] res_mask_q, res_mask_d;
  logic             res_sat_q, res_sat_d;

  logic             accept;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] step_oh;
  logic [WIDTH-1:0] step_mask;

  // in_ready only looks at registered state and out_ready, never at in_*.
  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == DONE);
  assign out_onehot = res_oh_q;
  assign out_mask   = res_mask_q;
  assign out_sat    = res_sat_q;

  // One shift stage per cycle; the top stage shifts by WIDTH, which clears the word.
  always_comb begin
    shamt     = CW'(1) << k_q;
    step_oh   = work_oh_q;
    step_mask = work_mask_q;
    if (n_q[k_q]) begin
      step_oh   = work_oh_q >> shamt;
      step_mask = work_mask_q >> shamt;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    sat_d       = sat_q;
    work_oh_d   = work_oh_q;
    work_mask_d = work_mask_q;
    res_oh_d    = res_oh_q;
    res_mask_d  = res_mask_q;
    res_sat_d   = res_sat_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        work_oh_d   = step_oh;
        work_mask_d = step_mask;
        if (k_q == K_LAST) begin
          state_d    = DONE;
          res_oh_d   = step_oh;
          res_mask_d = step_mask;
          res_sat_d  = sat_q;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides the DONE->IDLE path so back-to-back requests skip IDLE.
    if (accept) begin
      state_d     = RUN;
      k_d         = '0;
      n_d         = (in_count > N_MAX) ? N_MAX : in_count;
      sat_d       = (in_count > N_MAX);
      work_oh_d   = {1'b1, {(WIDTH-1){1'b0}}};
      work_mask_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      n_q         <= '0;
      sat_q       <= 1'b0;
      work_oh_q   <= '0;
      work_mask_q <= '0;
      res_oh_q    <= '0;
      res_mask_q  <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      sat_q       <= sat_d;
      work_oh_q   <= work_oh_d;
      work_mask_q <= work_mask_d;
      res_oh_q    <= res_oh_d;
      res_mask_q  <= res_mask_d;
      res_sat_q   <= res_sat_d;
    end
  end

endmodule

// File: tb/tb_clz_decode.sv
// Directed bench for clz_decode: vector table, back-pressure, reset abort and a full count sweep.
module tb_clz_decode;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = 6;
  localparam int LAT = 6;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_onehot;
  logic [WIDTH-1:0] out_mask;
  logic             out_sat;

  int checks;
  int failures;

  clz_decode #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_onehot(out_onehot),
    .out_mask  (out_mask),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] oh;
    logic [WIDTH-1:0] mask;
    logic             sat;
  } vec_t;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid, returning the number of edges it took (-1 on timeout).
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  function automatic int clz32(input logic [WIDTH-1:0] v);
    int c;
    c = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) break;
      c++;
    end
    return c;
  endfunction

  // Issue one request from IDLE, check latency and result, then take it.
  task automatic run_vec(input vec_t v);
    int cyc;
    chk($sformatf("in_ready_idle[%0d]", v.count), 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_count = v.count;
    tick();
    in_valid = 1'b0;
    in_count = ~v.count;
    wait_valid(cyc);
    chk($sformatf("latency[%0d]", v.count), 32'(cyc), 32'(LAT));
    chk($sformatf("onehot[%0d]", v.count), out_onehot, v.oh);
    chk($sformatf("mask[%0d]", v.count), out_mask, v.mask);
    chk($sformatf("sat[%0d]", v.count), 32'(out_sat), 32'(v.sat));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("valid_cleared[%0d]", v.count), 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int cyc;
    logic [WIDTH-1:0] hold_oh, hold_mask;
    logic stable, seen;

    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_count  = '0;
    out_ready = 1'b0;

    vecs[0] = '{6'd0,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[1] = '{6'd5,  32'h0400_0000, 32'h07FF_FFFF, 1'b0};
    vecs[2] = '{6'd31, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[3] = '{6'd32, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{6'd40, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{6'd1,  32'h4000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[6] = '{6'd16, 32'h0000_8000, 32'h0000_FFFF, 1'b0};
    vecs[7] = '{6'd21, 32'h0000_0400, 32'h0000_07FF, 1'b0};
    vecs[8] = '{6'd63, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[9] = '{6'd33, 32'h0000_0000, 32'h0000_0000, 1'b1};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_onehot", out_onehot, 32'h0);
    chk("rst_mask", out_mask, 32'h0);
    chk("rst_sat", 32'(out_sat), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Back-pressure, then same-cycle handoff to a new request.
    in_valid = 1'b1;
    in_count = 6'd7;
    tick();
    in_valid = 1'b0;
    wait_valid(cyc);
    chk("bp_latency", 32'(cyc), 32'(LAT));
    hold_oh   = out_onehot;
    hold_mask = out_mask;
    chk("bp_onehot", hold_oh, 32'h0100_0000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || in_ready || out_onehot !== hold_oh || out_mask !== hold_mask) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_count  = 6'd3;
    #1;
    chk("bp_same_cycle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_count  = 6'd0;
    chk("bp_no_bubble_valid", 32'(out_valid), 32'd0);
    chk("bp_no_bubble_busy", 32'(in_ready), 32'd0);
    wait_valid(cyc);
    chk("bp2_latency", 32'(cyc), 32'(LAT));
    chk("bp2_onehot", out_onehot, 32'h1000_0000);
    chk("bp2_mask", out_mask, 32'h1FFF_FFFF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset three cycles into a run aborts it.
    in_valid = 1'b1;
    in_count = 6'd2;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_onehot", out_onehot, 32'h0);
    chk("abort_mask", out_mask, 32'h0);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    chk("abort_no_stale", 32'(seen), 32'd0);

    // Full sweep against a reference model with random consumer stalls.
    for (int n = 0; n < 64; n++) begin
      logic [WIDTH-1:0] eoh, emask;
      logic esat;
      eoh   = (n >= 32) ? 32'h0 : (32'h8000_0000 >> n);
      emask = (n >= 32) ? 32'h0 : (32'hFFFF_FFFF >> n);
      esat  = (n > 32);
      in_valid = 1'b1;
      in_count = CW'(n);
      tick();
      in_valid = 1'b0;
      wait_valid(cyc);
      chk($sformatf("sweep_latency[%0d]", n), 32'(cyc), 32'(LAT));
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) tick();
      chk($sformatf("sweep_onehot[%0d]", n), out_onehot, eoh);
      chk($sformatf("sweep_mask[%0d]", n), out_mask, emask);
      chk($sformatf("sweep_sat[%0d]", n), 32'(out_sat), 32'(esat));
      if (n < 32) begin
        chk($sformatf("sweep_clz_onehot[%0d]", n), 32'(clz32(out_onehot)), 32'(n));
        chk($sformatf("sweep_clz_mask[%0d]", n), 32'(clz32(out_mask)), 32'(n));
        chk($sformatf("sweep_mask_rel[%0d]", n), out_mask, (out_onehot << 1) - 32'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
